apb_arbiter: RTL and testbench
==============================

// Module: apb_arbiter
// PURPOSE
//  Two-port APB interconnect sharing one APB slave (the sram-backed APB memory) between
//  requester 0 (instruction fetch) and requester 1 (load/store). Round-robin arbitration,
//  per-transfer grant, regenerated SETUP/ACCESS phases toward the slave, and a wait-state
//  watchdog that terminates hung transfers with perr.
// PARAMETERS
//  ADDR_WIDTH  32  address width, all ports
//  DATA_WIDTH  32  data width, all ports
//  TIMEOUT     16  max ACCESS cycles waiting for s_pready before forced error (>=2)
// PORTS
//  pclk         in   1           clock; all logic on rising edge
//  rst          in   1           synchronous, active-high reset
//  mN_paddr     in   ADDR_WIDTH  requester N address (N = 0,1; same set per requester)
//  mN_pdata     in   DATA_WIDTH  requester N write data
//  mN_psel      in   1           requester N select
//  mN_penable   in   1           requester N enable
//  mN_pwrite    in   1           requester N write
//  mN_pstb      in   4           requester N byte strobes
//  mN_prdata    out  DATA_WIDTH  read data to requester N
//  mN_pready    out  1           transfer complete to requester N
//  mN_perr      out  1           error to requester N
//  s_paddr/s_pdata/s_pwrite/s_pstb  out  as above  forwarded from granted requester
//  s_psel       out  1           slave select
//  s_penable    out  1           slave enable
//  s_prdata     in   DATA_WIDTH  slave read data
//  s_pready     in   1           slave ready
//  s_perr       in   1           slave error
// BEHAVIOUR
//  - Reset: state IDLE, last_grant=1 (so m0 wins first tie), wdog=0; s_psel=s_penable=0,
//    mN_pready=mN_perr=0, mN_prdata=0, s_paddr/s_pdata/s_pwrite/s_pstb=0.
//  - FSM IDLE -> SETUP -> ACCESS -> IDLE. Request N = mN_psel.
//  - IDLE: if any request, latch grant (g) and go SETUP. Both requesting: grant the one
//    != last_grant. One requesting: grant it. Update last_grant=g on grant.
//  - SETUP (1 cycle): s_psel=1, s_penable=0, s_* fields muxed from mg_*. -> ACCESS.
//  - ACCESS: s_psel=1, s_penable=1. If s_pready: mg_pready=1, mg_perr=s_perr,
//    mg_prdata=s_prdata (combinational, same cycle), -> IDLE. Else wdog++.
//  - Watchdog: in ACCESS with wdog==TIMEOUT-1 and !s_pready: mg_pready=1, mg_perr=1,
//    mg_prdata=0, -> IDLE (s_psel drops next cycle). wdog clears on leaving ACCESS.
//  - Non-granted requester: pready=0, perr=0, prdata=0 always; its psel/penable held by
//    the master per APB (wait states); it is served on a later arbitration.
//  - s_* address/data/ctl are forwarded combinationally from granted port in SETUP/ACCESS,
//    0 in IDLE. Requesters must hold fields stable until their pready (APB rule).
//  - Minimum latency: grant cycle (IDLE) + SETUP + ACCESS = 3 cycles from psel to pready
//    with zero-wait slave. Back-to-back: one IDLE cycle always separates transfers.
//  - Request dropped mid-transfer (protocol violation): transfer completes to slave anyway;
//    pready pulse is still driven.
//  - rst in any state: next cycle IDLE, s_psel=0; in-flight transfer abandoned, no pready.
// STRUCTURE
//  - apb_defs.vh: `define state encodings (ST_IDLE=2'd0, ST_SETUP=2'd1, ST_ACCESS=2'd2).
//  - Sub-module apb_rr_arb2: inputs req[1:0], last_grant; output grant index + valid.
//  - Top holds FSM, grant/last_grant regs, wdog counter ($clog2(TIMEOUT) bits), muxes.
// TESTING
//  - Reset: drive rst 2 cycles with m0_psel=1 -> s_psel=0, all pready=0; first grant m0.
//  - Single read m0 addr 0x10, slave pready at first ACCESS, prdata 0xDEADBEEF ->
//    m0_pready on cycle 3 with m0_prdata=0xDEADBEEF, m1_prdata=0.
//  - Simultaneous m0/m1 continuous requests -> grants alternate m0,m1,m0,m1; s_paddr
//    matches granted port; each transfer separated by one IDLE cycle.
//  - Write m1 addr 0x20 pdata 0x12345678 pstb 4'b0011, slave 2 wait states -> s_pwrite=1,
//    s_pstb=4'b0011 held through ACCESS; m1_pready after 2 waits, m1_perr=0.
//  - Slave never ready, TIMEOUT=16 -> m0_pready=m0_perr=1 on 16th ACCESS cycle,
//    s_psel=0 next cycle; subsequent m1 request served normally.
//  - rst asserted during ACCESS -> no pready pulse, s_psel=0 next cycle, last_grant=1.

Source files
------------

// File: rtl/apb_arbiter_pkg.sv
// Shared constants for the two-port APB arbiter: FSM encodings and port count.
package apb_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam int NPORTS = 2;

endpackage

// File: rtl/apb_arbiter_rr_arb2.sv
// Two-requester round-robin picker: on a tie the port that did not win last time wins.
module apb_rr_arb2
  import apb_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = 1'b0;
    if (&req) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// Shares one APB slave between two requesters with per-transfer round-robin grant,
// regenerated SETUP/ACCESS phases and a wait-state watchdog that forces perr.
module apb_arbiter
  import apb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m0_paddr,
  input  logic [DATA_WIDTH-1:0] m0_pdata,
  input  logic                  m0_psel,
  input  logic                  m0_penable,
  input  logic                  m0_pwrite,
  input  logic [3:0]            m0_pstb,
  output logic [DATA_WIDTH-1:0] m0_prdata,
  output logic                  m0_pready,
  output logic                  m0_perr,
  input  logic [ADDR_WIDTH-1:0] m1_paddr,
  input  logic [DATA_WIDTH-1:0] m1_pdata,
  input  logic                  m1_psel,
  input  logic                  m1_penable,
  input  logic                  m1_pwrite,
  input  logic [3:0]            m1_pstb,
  output logic [DATA_WIDTH-1:0] m1_prdata,
  output logic                  m1_pready,
  output logic                  m1_perr,
  output logic [ADDR_WIDTH-1:0] s_paddr,
  output logic [DATA_WIDTH-1:0] s_pdata,
  output logic                  s_pwrite,
  output logic [3:0]            s_pstb,
  output logic                  s_psel,
  output logic                  s_penable,
  input  logic [DATA_WIDTH-1:0] s_prdata,
  input  logic                  s_pready,
  input  logic                  s_perr
);

  localparam int WDOG_W = $clog2(TIMEOUT);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT - 1);

  logic [1:0]        state_reg, state_next;
  logic              grant_reg, last_grant_reg;
  logic [WDOG_W-1:0] wdog_reg;
  logic              arb_grant, arb_valid;
  logic              busy, in_access, xfer_ok, xfer_tmo, wdog_hit;

  logic [ADDR_WIDTH-1:0] m_paddr  [NPORTS];
  logic [DATA_WIDTH-1:0] m_pdata  [NPORTS];
  logic [DATA_WIDTH-1:0] m_prdata [NPORTS];
  logic [3:0]            m_pstb   [NPORTS];
  logic [NPORTS-1:0]     m_psel, m_pwrite, m_pready, m_perr;

  // penable from the requesters carries no information the regenerated phases need.
  logic unused_penable;
  assign unused_penable = m0_penable ^ m1_penable;

  assign m_paddr[0] = m0_paddr;
  assign m_paddr[1] = m1_paddr;
  assign m_pdata[0] = m0_pdata;
  assign m_pdata[1] = m1_pdata;
  assign m_pstb[0]  = m0_pstb;
  assign m_pstb[1]  = m1_pstb;
  assign m_psel     = {m1_psel, m0_psel};
  assign m_pwrite   = {m1_pwrite, m0_pwrite};

  apb_rr_arb2 u_arb (
    .req        (m_psel),
    .last_grant (last_grant_reg),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  assign busy      = (state_reg != ST_IDLE);
  assign wdog_hit  = (wdog_reg == WDOG_MAX);
  // Completion is suppressed while rst is high so an abandoned transfer never pulses pready.
  assign in_access = (state_reg == ST_ACCESS) && !rst;
  assign xfer_ok   = in_access && s_pready;
  assign xfer_tmo  = in_access && !s_pready && wdog_hit;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (arb_valid) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: if (s_pready || wdog_hit) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      wdog_reg       <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && arb_valid) begin
        grant_reg      <= arb_grant;
        last_grant_reg <= arb_grant;
      end
      if (state_reg == ST_ACCESS && state_next == ST_ACCESS) begin
        wdog_reg <= wdog_reg + 1'b1;
      end else begin
        wdog_reg <= '0;
      end
    end
  end

  assign s_psel    = busy;
  assign s_penable = (state_reg == ST_ACCESS);
  assign s_paddr   = busy ? m_paddr[grant_reg]  : '0;
  assign s_pdata   = busy ? m_pdata[grant_reg]  : '0;
  assign s_pwrite  = busy ? m_pwrite[grant_reg] : 1'b0;
  assign s_pstb    = busy ? m_pstb[grant_reg]   : 4'd0;

  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_resp
    logic sel;
    assign sel          = (grant_reg == 1'(gi));
    assign m_pready[gi] = sel && (xfer_ok || xfer_tmo);
    assign m_perr[gi]   = sel && ((xfer_ok && s_perr) || xfer_tmo);
    assign m_prdata[gi] = (sel && xfer_ok) ? s_prdata : '0;
  end

  assign m0_pready = m_pready[0];
  assign m1_pready = m_pready[1];
  assign m0_perr   = m_perr[0];
  assign m1_perr   = m_perr[1];
  assign m0_prdata = m_prdata[0];
  assign m1_prdata = m_prdata[1];

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: reset, single read, round-robin, wait states, watchdog, reset abort.
module tb_apb_arbiter;

  logic        pclk = 1'b0;
  logic        rst;
  logic [31:0] m0_paddr, m0_pdata, m0_prdata, m1_paddr, m1_pdata, m1_prdata;
  logic        m0_psel, m0_penable, m0_pwrite, m0_pready, m0_perr;
  logic        m1_psel, m1_penable, m1_pwrite, m1_pready, m1_perr;
  logic [3:0]  m0_pstb, m1_pstb, s_pstb;
  logic [31:0] s_paddr, s_pdata, s_prdata;
  logic        s_pwrite, s_psel, s_penable, s_pready, s_perr;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 pclk = ~pclk;

  apb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .pclk(pclk), .rst(rst),
    .m0_paddr(m0_paddr), .m0_pdata(m0_pdata), .m0_psel(m0_psel), .m0_penable(m0_penable),
    .m0_pwrite(m0_pwrite), .m0_pstb(m0_pstb), .m0_prdata(m0_prdata), .m0_pready(m0_pready),
    .m0_perr(m0_perr),
    .m1_paddr(m1_paddr), .m1_pdata(m1_pdata), .m1_psel(m1_psel), .m1_penable(m1_penable),
    .m1_pwrite(m1_pwrite), .m1_pstb(m1_pstb), .m1_prdata(m1_prdata), .m1_pready(m1_pready),
    .m1_perr(m1_perr),
    .s_paddr(s_paddr), .s_pdata(s_pdata), .s_pwrite(s_pwrite), .s_pstb(s_pstb),
    .s_psel(s_psel), .s_penable(s_penable), .s_prdata(s_prdata), .s_pready(s_pready),
    .s_perr(s_perr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance one clock; outputs are examined 1 ns after the rising edge.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_paddr = 32'h10; m0_pdata = '0; m0_psel = 1'b1; m0_penable = 1'b0; m0_pwrite = 1'b0; m0_pstb = 4'hF;
    m1_paddr = '0; m1_pdata = '0; m1_psel = 1'b0; m1_penable = 1'b0; m1_pwrite = 1'b0; m1_pstb = 4'h0;
    s_prdata = 32'hDEADBEEF; s_pready = 1'b1; s_perr = 1'b0;

    // Reset held two cycles with m0 requesting
    tick();
    chk("rst_s_psel", 32'(s_psel), 32'd0);
    tick();
    chk("rst_m0_pready", 32'(m0_pready), 32'd0);
    chk("rst_m1_pready", 32'(m1_pready), 32'd0);
    chk("rst_m0_prdata", m0_prdata, 32'd0);
    chk("rst_s_paddr", s_paddr, 32'd0);
    rst = 1'b0;
    #1;

    // Single zero-wait read from m0: IDLE, SETUP, ACCESS
    chk("rd_idle_s_psel", 32'(s_psel), 32'd0);
    tick();
    chk("rd_setup_s_psel", 32'(s_psel), 32'd1);
    chk("rd_setup_s_penable", 32'(s_penable), 32'd0);
    chk("rd_setup_s_paddr", s_paddr, 32'h10);
    chk("rd_setup_m0_pready", 32'(m0_pready), 32'd0);
    tick();
    chk("rd_access_s_penable", 32'(s_penable), 32'd1);
    chk("rd_m0_pready", 32'(m0_pready), 32'd1);
    chk("rd_m0_prdata", m0_prdata, 32'hDEADBEEF);
    chk("rd_m0_perr", 32'(m0_perr), 32'd0);
    chk("rd_m1_prdata", m1_prdata, 32'd0);
    chk("rd_m1_pready", 32'(m1_pready), 32'd0);
    m0_psel = 1'b0;
    tick();
    chk("rd_done_s_psel", 32'(s_psel), 32'd0);
    chk("rd_done_m0_pready", 32'(m0_pready), 32'd0);

    // Round-robin from a fresh reset: m0 wins the first tie, then strict alternation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m0_paddr = 32'h100; m1_paddr = 32'h200;
    m0_psel = 1'b1; m1_psel = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_addr;
      exp_addr = (i % 2 == 0) ? 32'h100 : 32'h200;
      chk($sformatf("rr%0d_idle_s_psel", i), 32'(s_psel), 32'd0);
      tick();
      chk($sformatf("rr%0d_s_paddr", i), s_paddr, exp_addr);
      tick();
      chk($sformatf("rr%0d_m0_pready", i), 32'(m0_pready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_m1_pready", i), 32'(m1_pready), (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i == 3) begin
        m0_psel = 1'b0; m1_psel = 1'b0;
      end
      tick();
    end

    // m1 write with two wait states
    s_pready = 1'b0;
    m1_paddr = 32'h20; m1_pdata = 32'h12345678; m1_pstb = 4'b0011; m1_pwrite = 1'b1; m1_psel = 1'b1;
    tick();
    chk("wr_setup_s_pwrite", 32'(s_pwrite), 32'd1);
    chk("wr_setup_s_pdata", s_pdata, 32'h12345678);
    chk("wr_setup_s_paddr", s_paddr, 32'h20);
    tick();
    chk("wr_wait1_s_pstb", 32'(s_pstb), 32'h3);
    chk("wr_wait1_m1_pready", 32'(m1_pready), 32'd0);
    tick();
    chk("wr_wait2_s_pwrite", 32'(s_pwrite), 32'd1);
    chk("wr_wait2_m1_pready", 32'(m1_pready), 32'd0);
    tick();
    s_pready = 1'b1;
    #1;
    chk("wr_m1_pready", 32'(m1_pready), 32'd1);
    chk("wr_m1_perr", 32'(m1_perr), 32'd0);
    chk("wr_s_pstb", 32'(s_pstb), 32'h3);
    chk("wr_m0_pready", 32'(m0_pready), 32'd0);
    m1_psel = 1'b0; m1_pwrite = 1'b0;
    tick();
    s_pready = 1'b0;

    // Slave never ready: watchdog fires on the 16th ACCESS cycle
    s_prdata = 32'hCAFEF00D;
    m0_paddr = 32'h40; m0_psel = 1'b1;
    tick();
    tick();
    for (int k = 1; k < 16; k++) begin
      chk($sformatf("tmo_access%0d_m0_pready", k), 32'(m0_pready), 32'd0);
      tick();
    end
    chk("tmo_m0_pready", 32'(m0_pready), 32'd1);
    chk("tmo_m0_perr", 32'(m0_perr), 32'd1);
    chk("tmo_m0_prdata", m0_prdata, 32'd0);
    chk("tmo_s_psel_last", 32'(s_psel), 32'd1);
    m0_psel = 1'b0;
    m1_paddr = 32'h80; m1_psel = 1'b1;
    tick();
    chk("tmo_after_s_psel", 32'(s_psel), 32'd0);
    chk("tmo_after_m0_pready", 32'(m0_pready), 32'd0);
    tick();
    chk("tmo_m1_s_paddr", s_paddr, 32'h80);
    s_pready = 1'b1;
    tick();
    chk("tmo_m1_pready", 32'(m1_pready), 32'd1);
    chk("tmo_m1_perr", 32'(m1_perr), 32'd0);
    chk("tmo_m1_prdata", m1_prdata, 32'hCAFEF00D);
    m1_psel = 1'b0;
    tick();

    // Reset during ACCESS of an m0 transfer: no pready, grant history restored
    s_pready = 1'b0;
    m0_paddr = 32'h300; m0_psel = 1'b1;
    tick();
    tick();
    chk("rstacc_s_penable", 32'(s_penable), 32'd1);
    rst = 1'b1; s_pready = 1'b1;
    #1;
    chk("rstacc_m0_pready", 32'(m0_pready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rstacc_s_psel", 32'(s_psel), 32'd0);
    chk("rstacc_after_m0_pready", 32'(m0_pready), 32'd0);
    m1_paddr = 32'h400; m1_psel = 1'b1;
    tick();
    chk("rstacc_tie_s_paddr", s_paddr, 32'h300);
    tick();
    chk("rstacc_tie_m0_pready", 32'(m0_pready), 32'd1);
    m0_psel = 1'b0; m1_psel = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
